// File: rtl/can_rx_deserializer_pkg.sv
// Shared types and constants for the CAN RX data-field deserializer.
package can_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } rx_state_t;

    localparam int CAN_MAX_DLC   = 8;
    localparam int BITS_PER_BYTE = 8;

    // DLC codes above the payload capacity all mean "full payload".
    function automatic logic [3:0] clamp_dlc(input logic [3:0] dlc, input int max_bytes);
        logic [31:0] mb;
        mb = max_bytes;
        return (32'(dlc) > mb) ? mb[3:0] : dlc;
    endfunction

endpackage

// File: rtl/can_rx_deserializer_if.sv
// Bit-sample side inputs and RX frame register side outputs of the deserializer.
interface can_rx_deserializer_if
    import can_pkg::*;
#(
    parameter int MAX_BYTES = CAN_MAX_DLC
);
    logic                   rx_sample;
    logic                   rx_bit;
    logic                   dataphase;
    logic                   bitstuff;
    logic [3:0]             pkt_size;
    logic                   byte_complete;
    logic [3:0]             byte_num;
    logic [7:0]             rx_byte;
    logic                   end_data;
    logic [8*MAX_BYTES-1:0] data_out;
    logic                   rx_err;

    modport master (
        output rx_sample, rx_bit, dataphase, bitstuff, pkt_size,
        input  byte_complete, byte_num, rx_byte, end_data, data_out, rx_err
    );

    modport slave (
        input  rx_sample, rx_bit, dataphase, bitstuff, pkt_size,
        output byte_complete, byte_num, rx_byte, end_data, data_out, rx_err
    );
endinterface

// File: rtl/can_rx_deserializer_stuff_checker.sv
// Run-length tracker flagging CAN stuff violations; built only with CAN_RX_STUFF_CHECK_EN.
`ifdef CAN_RX_STUFF_CHECK_EN
module can_stuff_checker
    import can_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic active,
    input  logic rx_sample,
    input  logic rx_bit,
    input  logic bitstuff,
    output logic stuff_err
);
    logic       run_bit;
    logic [2:0] run_len;
    logic       smp;
    logic       same;

    assign smp  = active & rx_sample;
    assign same = (run_len != 3'd0) && (rx_bit == run_bit);

    // A stuff bit must oppose the run; a sixth equal data bit means a stuff bit was missed.
    assign stuff_err = smp && (bitstuff ? same : (same && run_len == 3'd5));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_bit <= 1'b0;
            run_len <= 3'd0;
        end else if (clear) begin
            run_bit <= 1'b0;
            run_len <= 3'd0;
        end else if (smp) begin
            if (bitstuff) begin
                run_len <= 3'd0;
            end else if (same) begin
                run_len <= (run_len == 3'd7) ? 3'd7 : run_len + 3'd1;
            end else begin
                run_bit <= rx_bit;
                run_len <= 3'd1;
            end
        end
    end
endmodule
`endif

// File: rtl/can_rx_deserializer.sv
// CAN RX data-field deserializer: drops stuff bits, packs bytes MSB-first, tracks DLC.
// Optional stuff-error detection with CAN_RX_STUFF_CHECK_EN.
module can_rx_deserializer
    import can_pkg::*;
#(
    parameter int MAX_BYTES = CAN_MAX_DLC
)(
    input logic                 clk,
    input logic                 RST,
    can_rx_deserializer_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0]             state;
    logic [3:0]             len;
    logic [2:0]             bit_cnt;
    logic [7:0]             shift_reg;
    logic                   byte_complete;
    logic [3:0]             byte_num;
    logic [7:0]             rx_byte;
    logic                   end_data;
    logic [8*MAX_BYTES-1:0] data_out;
    logic                   rx_err;

    logic       take_bit;
    logic [7:0] next_byte;
    logic [3:0] next_num;
    logic [3:0] start_len;
    logic       stuff_err;

    assign take_bit  = (state == ST_SHIFT) && bus.dataphase && bus.rx_sample && !bus.bitstuff;
    assign next_byte = {shift_reg[BITS_PER_BYTE-2:0], bus.rx_bit};
    assign next_num  = byte_num + 4'd1;
    assign start_len = clamp_dlc(bus.pkt_size, MAX_BYTES);

`ifdef CAN_RX_STUFF_CHECK_EN
    can_stuff_checker u_stuff_chk (
        .clk       (clk),
        .rst       (RST),
        .clear     (state == ST_IDLE),
        .active    ((state == ST_SHIFT) && bus.dataphase),
        .rx_sample (bus.rx_sample),
        .rx_bit    (bus.rx_bit),
        .bitstuff  (bus.bitstuff),
        .stuff_err (stuff_err)
    );
`else
    assign stuff_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state         <= ST_IDLE;
            len           <= 4'd0;
            bit_cnt       <= 3'd0;
            shift_reg     <= 8'd0;
            byte_complete <= 1'b0;
            byte_num      <= 4'd0;
            rx_byte       <= 8'd0;
            end_data      <= 1'b0;
            data_out      <= '0;
            rx_err        <= 1'b0;
        end else begin
            byte_complete <= 1'b0;
            end_data      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.dataphase) begin
                        len       <= start_len;
                        data_out  <= '0;
                        byte_num  <= 4'd0;
                        rx_err    <= 1'b0;
                        bit_cnt   <= 3'd0;
                        shift_reg <= 8'd0;
                        if (start_len == 4'd0) begin
                            end_data <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (!bus.dataphase) begin
                        // Abort: partial byte is dropped, completed bytes stay visible.
                        state     <= ST_IDLE;
                        bit_cnt   <= 3'd0;
                        shift_reg <= 8'd0;
                        if (byte_num < len) rx_err <= 1'b1;
                    end else begin
                        if (stuff_err) rx_err <= 1'b1;
                        if (take_bit) begin
                            shift_reg <= next_byte;
                            bit_cnt   <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'(BITS_PER_BYTE - 1)) begin
                                byte_complete <= 1'b1;
                                rx_byte       <= next_byte;
                                byte_num      <= next_num;
                                for (int i = 0; i < MAX_BYTES; i++)
                                    if (byte_num == 4'(i))
                                        data_out[8*(MAX_BYTES-1-i) +: 8] <= next_byte;
                                if (next_num == len) begin
                                    end_data <= 1'b1;
                                    state    <= ST_DONE;
                                end
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (!bus.dataphase) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.byte_complete = byte_complete;
    assign bus.byte_num      = byte_num;
    assign bus.rx_byte       = rx_byte;
    assign bus.end_data      = end_data;
    assign bus.data_out      = data_out;
    assign bus.rx_err        = rx_err;

endmodule

// File: tb/tb_can_rx_deserializer.sv
// Scoreboard bench for can_rx_deserializer: directed frames, monitor pops expected byte events.
module tb_can_rx_deserializer;
    import can_pkg::*;

    logic clk = 1'b0;
    logic RST;
    always #5 clk = ~clk;

    can_rx_deserializer_if #(.MAX_BYTES(8)) bus ();

    can_rx_deserializer #(.MAX_BYTES(8)) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus.slave)
    );

    typedef struct {
        logic        bc;
        logic        ed;
        logic [7:0]  b;
        logic [3:0]  n;
        logic [63:0] d;
        logic        chk_d;
        int          gap;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_bc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every strobe from the DUT must match the next expected event.
    always @(negedge clk) begin
        if (RST === 1'b0 && (bus.byte_complete === 1'b1 || bus.end_data === 1'b1)) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_event: byte_complete=%b end_data=%b byte_num=%0d expected none",
                         bus.byte_complete, bus.end_data, bus.byte_num);
            end else begin
                me = sb.pop_front();
                chk("byte_complete", 64'(bus.byte_complete), 64'(me.bc));
                chk("end_data", 64'(bus.end_data), 64'(me.ed));
                chk("byte_num", 64'(bus.byte_num), 64'(me.n));
                if (me.bc) chk("rx_byte", 64'(bus.rx_byte), 64'(me.b));
                if (me.chk_d) chk("data_out", bus.data_out, me.d);
                if (me.gap > 0) chk("byte_gap", 64'(cyc - last_bc), 64'(me.gap));
            end
            if (bus.byte_complete === 1'b1) last_bc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic bc, input logic ed, input logic [7:0] b, input logic [3:0] n,
                        input logic [63:0] d, input logic chk_d, input int gap);
        exp_t e;
        e.bc = bc; e.ed = ed; e.b = b; e.n = n; e.d = d; e.chk_d = chk_d; e.gap = gap;
        sb.push_back(e);
    endtask

    task automatic send(input logic b, input logic st);
        bus.rx_sample = 1'b1;
        bus.rx_bit    = b;
        bus.bitstuff  = st;
        tick();
        bus.rx_sample = 1'b0;
        bus.bitstuff  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input bit idle_after);
        for (int i = 7; i >= 0; i--) send(v[i], 1'b0);
        if (idle_after) tick();
    endtask

    task automatic start(input logic [3:0] dlc);
        bus.pkt_size  = dlc;
        bus.dataphase = 1'b1;
        tick();
    endtask

    task automatic stop();
        bus.dataphase = 1'b0;
        tick();
        tick();
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 50) begin
            tick();
            k++;
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d events outstanding expected 0", nm, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        logic [63:0] pay;
        logic [7:0]  bv;
        logic        exp_stuff_err;

        RST           = 1'b1;
        bus.rx_sample = 1'b0;
        bus.rx_bit    = 1'b0;
        bus.dataphase = 1'b0;
        bus.bitstuff  = 1'b0;
        bus.pkt_size  = 4'd0;
        repeat (3) tick();
        chk("reset_byte_num", 64'(bus.byte_num), 64'd0);
        chk("reset_rx_byte", 64'(bus.rx_byte), 64'd0);
        chk("reset_data_out", bus.data_out, 64'd0);
        chk("reset_rx_err", 64'(bus.rx_err), 64'd0);
        chk("reset_strobes", 64'({bus.byte_complete, bus.end_data}), 64'd0);
        RST = 1'b0;
        tick();

        // Single byte 0xA5
        push(1, 1, 8'hA5, 4'd1, 64'hA500_0000_0000_0000, 1, 0);
        start(4'd1);
        send_byte(8'hA5, 0);
        drain("single");
        chk("single_rx_err", 64'(bus.rx_err), 64'd0);
        stop();

        // 0x00 then 0xFF with stuff bits after each run of five
        push(1, 0, 8'h00, 4'd1, 64'd0, 0, 0);
        push(1, 1, 8'hFF, 4'd2, 64'h00FF_0000_0000_0000, 1, 0);
        start(4'd2);
        for (int i = 0; i < 5; i++) send(1'b0, 1'b0);
        send(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) send(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send(1'b1, 1'b0);
        send(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) send(1'b1, 1'b0);
        drain("stuff_skip");
        chk("stuff_skip_rx_err", 64'(bus.rx_err), 64'd0);
        stop();

        // DLC=0: end_data only, one clk after dataphase rises
        push(0, 1, 8'h00, 4'd0, 64'd0, 1, 0);
        start(4'd0);
        drain("dlc0");
        tick();
        stop();

        // DLC=12 clamps to 8 bytes
        d = 64'd0;
        for (int i = 0; i < 8; i++) begin
            bv = 8'(i * 8'h11 + 1);
            d[63 - 8*i -: 8] = bv;
            push(1, (i == 7), bv, 4'(i + 1), d, (i == 7), 0);
        end
        start(4'd12);
        for (int i = 0; i < 8; i++) send_byte(8'(i * 8'h11 + 1), 1);
        drain("dlc12");
        stop();

        // Abort after 2 bytes + 3 bits of a DLC=4 frame
        push(1, 0, 8'h11, 4'd1, 64'd0, 0, 0);
        push(1, 0, 8'h22, 4'd2, 64'h1122_0000_0000_0000, 1, 0);
        start(4'd4);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b1, 1'b0);
        drain("abort");
        bus.dataphase = 1'b0;
        tick();
        chk("abort_rx_err", 64'(bus.rx_err), 64'd1);
        chk("abort_byte_num", 64'(bus.byte_num), 64'd2);
        chk("abort_data_out", bus.data_out, 64'h1122_0000_0000_0000);
        tick();
        push(1, 1, 8'h3C, 4'd1, 64'h3C00_0000_0000_0000, 1, 0);
        start(4'd1);
        chk("next_frame_rx_err", 64'(bus.rx_err), 64'd0);
        chk("next_frame_data_out", bus.data_out, 64'd0);
        chk("next_frame_byte_num", 64'(bus.byte_num), 64'd0);
        send_byte(8'h3C, 0);
        drain("after_abort");
        stop();

        // Back-to-back samples, 8-byte payload
        pay = 64'h0123_4567_89AB_CDEF;
        d = 64'd0;
        for (int i = 0; i < 8; i++) begin
            d[63 - 8*i -: 8] = pay[63 - 8*i -: 8];
            push(1, (i == 7), pay[63 - 8*i -: 8], 4'(i + 1), d, (i == 7), (i == 0) ? 0 : 8);
        end
        start(4'd8);
        for (int i = 63; i >= 0; i--) send(pay[i], 1'b0);
        drain("b2b");
        stop();

        // Five zeros then a zero stuff bit
`ifdef CAN_RX_STUFF_CHECK_EN
        exp_stuff_err = 1'b1;
`else
        exp_stuff_err = 1'b0;
`endif
        push(1, 1, 8'h00, 4'd1, 64'd0, 1, 0);
        start(4'd1);
        for (int i = 0; i < 5; i++) send(1'b0, 1'b0);
        chk("pre_stuff_rx_err", 64'(bus.rx_err), 64'd0);
        send(1'b0, 1'b1);
        chk("stuff_err_rx_err", 64'(bus.rx_err), 64'(exp_stuff_err));
        for (int i = 0; i < 3; i++) send(1'b0, 1'b0);
        drain("stuff_err");
        chk("stuff_err_sticky", 64'(bus.rx_err), 64'(exp_stuff_err));
        stop();

        // Asynchronous reset mid-SHIFT
        push(1, 0, 8'h5A, 4'd1, 64'h5A00_0000_0000_0000, 1, 0);
        start(4'd2);
        send_byte(8'h5A, 0);
        send(1'b1, 1'b0); send(1'b1, 1'b0); send(1'b0, 1'b0);
        drain("pre_reset");
        #2;
        RST = 1'b1;
        #1;
        chk("async_byte_num", 64'(bus.byte_num), 64'd0);
        chk("async_rx_byte", 64'(bus.rx_byte), 64'd0);
        chk("async_data_out", bus.data_out, 64'd0);
        chk("async_rx_err", 64'(bus.rx_err), 64'd0);
        chk("async_strobes", 64'({bus.byte_complete, bus.end_data}), 64'd0);
        bus.dataphase = 1'b0;
        tick();
        RST = 1'b0;
        tick();

        chk("final_queue_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/can_rx_deserializer.md
Name: can_rx_deserializer

Overview:
- Receive-side counterpart of the CAN TX data-phase timing: samples data-field bits, drops stuff bits, assembles bytes MSB-first and tracks the byte count against the received DLC.
- Sits between the CAN bit-timing/sample logic and the Wishbone-facing RX frame registers.
- Produces the per-byte strobe, the running byte index, end-of-data and the assembled 8-byte payload.

Parameters:
- MAX_BYTES, 8, payload capacity in bytes; DLC values above it are clamped to it.

Ports:
- clk  input  1  system clock
- RST  input  1  asynchronous active-high reset
- rx_sample  input  1  single-cycle strobe at the bit sample point
- rx_bit  input  1  sampled bus value, valid when rx_sample=1
- dataphase  input  1  high while the data field is on the bus
- bitstuff  input  1  current sampled bit is a stuff bit; qualifies rx_sample
- pkt_size  input  4  received DLC, sampled on frame start
- byte_complete  output  1  one-clk pulse, new byte available on rx_byte
- byte_num  output  4  count of completed bytes in this frame (0..MAX_BYTES)
- rx_byte  output  8  last completed byte
- end_data  output  1  one-clk pulse, all DLC bytes received
- data_out  output  8*MAX_BYTES  payload; byte 0 in the most significant byte
- rx_err  output  1  sticky error flag, cleared at frame start

Behaviour:
- Reset: all outputs 0; FSM in IDLE; bit counter 0; shift register 0.
- FSM states:
  - IDLE: on dataphase=1, latch len = min(pkt_size, MAX_BYTES), clear data_out, byte_num and rx_err, then go to SHIFT. If len=0, go to DONE and pulse end_data the next clk.
  - SHIFT: each rx_sample with bitstuff=0 shifts rx_bit into the shift register LSB (MSB-first on bus) and increments the 3-bit bit counter. rx_sample with bitstuff=1 is ignored.
  - On the 8th data bit:
    - One clk after that sample, pulse byte_complete, set rx_byte, write data_out byte[byte_num], and increment byte_num.
    - The bit counter wraps to 0.
    - If the new byte_num equals len, pulse end_data in the same clk and go to DONE.
  - DONE: ignore all samples. Return to IDLE when dataphase=0.
- dataphase falling in SHIFT (abort):
  - Go to IDLE and discard the partial byte.
  - If byte_num is less than len, set rx_err.
  - data_out and byte_num hold their values until the next frame start.
- rx_sample without dataphase is ignored.
- All outputs are registered. Output latency is 1 clk from the qualifying rx_sample edge.
- byte_complete and end_data never last longer than 1 clk. end_data coincides with the final byte_complete, except when len=0.
- Back-to-back rx_sample on consecutive clks must be accepted with no lost bits.

Optional Feature:
- Macro: CAN_RX_STUFF_CHECK_EN
- Defined:
  - An internal run-length tracker counts consecutive equal non-stuff bits during SHIFT.
  - A sample with bitstuff=1 whose value equals the preceding run bit sets rx_err. This is a stuff error.
  - Six equal bits without an intervening bitstuff sample also set rx_err.
  - Deserialization continues after the error; the MAC decides to discard the frame.
- Not defined: the tracker logic is absent; rx_err reflects only an aborted/short data phase.

Decomposition:
- Package can_pkg holds:
  - typedef enum rx_state_t {IDLE, SHIFT, DONE};
  - localparam CAN_MAX_DLC = 8;
  - localparam BITS_PER_BYTE = 8.
- One natural sub-module: can_stuff_checker (run-length tracker), instantiated only under CAN_RX_STUFF_CHECK_EN.

Test Plan:
- Single byte:
  - Stimulus: DLC=1, bits 1010_0101, no stuff.
  - Required: byte_complete once, rx_byte=0xA5, byte_num=1, end_data with the byte_complete, data_out[63:56]=0xA5.
- Stuff skip:
  - Stimulus: DLC=2, bytes 0x00 and 0xFF with a stuff bit (bitstuff=1) after every 5 equal bits.
  - Required: rx_byte values 0x00 then 0xFF, byte_num=2, no rx_err.
- DLC edge cases:
  - Stimulus: DLC=0.
  - Required: end_data pulses 1 clk after dataphase rise, no byte_complete.
  - Stimulus: DLC=12.
  - Required: exactly 8 bytes, end_data at byte_num=8.
- Abort:
  - Stimulus: DLC=4, dataphase drops after 2 bytes plus 3 bits.
  - Required: rx_err=1, byte_num=2, no end_data, IDLE. The next frame clears rx_err and data_out.
- Back-to-back:
  - Stimulus: rx_sample every clk, 8-byte payload 0x0123456789ABCDEF.
  - Required: data_out matches, 8 byte_complete pulses spaced 8 clks apart.
- Stuff error (macro on):
  - Stimulus: 5 zeros followed by a bitstuff sample of 0.
  - Required: rx_err=1 1 clk later.
  - Macro off: same stimulus gives rx_err=0.
- Reset: RST asserted mid-SHIFT forces all outputs to 0 immediately (asynchronous).
